// File: rtl/alu181_seq.sv
// alu181_seq: WIDTH-bit 74181-style ALU evaluated as a chain of 4-bit slices, PAR slices per clock
//
// Ports
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   in_valid / in_ready       request handshake; in_ready is high only in IDLE
//   a, b, s, m, cn_n          operands, function select, logic/arith mode, active-low carry-in
//   acc_en, acc_clr           use/update the accumulator as operand A; clear the accumulator
//   out_valid / out_ready     result handshake; result held until out_ready
//   f, cout_n, aeqb, acc      result, active-low carry-out, all-ones flag, accumulator
//
// Timing: the accept edge moves to RUN, which lasts NSL/PAR cycles; the last RUN edge
// commits f/cout_n/aeqb/acc and enters DONE, so out_valid is up on the NSL/PAR+1-th edge
// counting the accept edge.
module alu181_seq #(
    parameter int WIDTH = 8,
    parameter int PAR   = 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_n,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cout_n,
    output logic             aeqb,
    output logic [WIDTH-1:0] acc
);
    localparam int NSL = WIDTH / 4;
    localparam int KW  = $clog2(NSL + 1);
    localparam int IW  = $clog2(WIDTH);
    localparam logic [KW-1:0] K_STEP = KW'(PAR);
    localparam logic [KW-1:0] K_LAST = KW'(NSL - PAR);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d, acc_q, acc_d, f_run;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d, acc_en_q, acc_en_d, c_q, c_d;
    logic             cout_n_q, cout_n_d, aeqb_q, aeqb_d, carry;
    logic [KW-1:0]    k_q, k_d;
    logic [IW-1:0]    idx;
    logic [4:0]       r;

    // One 74181 slice: {carry_out, F}. Logic mode produces no carry.
    function automatic logic [4:0] slice181(input logic [3:0] av, input logic [3:0] bv,
                                            input logic [3:0] sv, input logic mv, input logic cv);
        logic [3:0] x, y;
        x = av | ((bv & {4{sv[0]}}) | (~bv & {4{sv[1]}}));
        y = av & ((bv & {4{sv[3]}}) | (~bv & {4{sv[2]}}));
        return mv ? {1'b0, ~(x ^ y)} : ({1'b0, x} + {1'b0, y} + {4'b0, cv});
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign f         = f_q;
    assign cout_n    = cout_n_q;
    assign aeqb      = aeqb_q;
    assign acc       = acc_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        m_d      = m_q;
        acc_en_d = acc_en_q;
        c_d      = c_q;
        k_d      = k_q;
        f_d      = f_q;
        cout_n_d = cout_n_q;
        aeqb_d   = aeqb_q;
        acc_d    = acc_q;
        carry    = c_q;
        f_run    = f_q;
        r        = '0;
        idx      = '0;
        // Ripple through the PAR slices starting at slice k.
        for (int i = 0; i < PAR; i++) begin
            idx = IW'(4 * (int'(k_q) + i));
            r = slice181(a_q[idx +: 4], b_q[idx +: 4], s_q, m_q, carry);
            f_run[idx +: 4] = r[3:0];
            carry = r[4];
        end
        case (state_q)
            IDLE: if (in_valid) begin
                a_d      = acc_en ? acc_q : a;
                b_d      = b;
                s_d      = s;
                m_d      = m;
                acc_en_d = acc_en;
                c_d      = ~cn_n;
                k_d      = '0;
                f_d      = '0;
                state_d  = RUN;
            end
            RUN: begin
                f_d = f_run;
                c_d = carry;
                k_d = k_q + K_STEP;
                if (k_q == K_LAST) begin
                    cout_n_d = m_q | ~carry;
                    aeqb_d   = &f_run;
                    acc_d    = acc_en_q ? f_run : acc_q;
                    state_d  = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Clear wins over a result write on the same edge.
        if (acc_clr) acc_d = '0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            acc_en_q <= 1'b0;
            c_q      <= 1'b0;
            k_q      <= '0;
            f_q      <= '0;
            cout_n_q <= 1'b1;
            aeqb_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            acc_en_q <= acc_en_d;
            c_q      <= c_d;
            k_q      <= k_d;
            f_q      <= f_d;
            cout_n_q <= cout_n_d;
            aeqb_q   <= aeqb_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: tb/tb_alu181_seq.sv
// tb_alu181_seq: scoreboard bench driving a PAR=1 and a PAR=2 instance with shared stimulus
module tb_alu181_seq;
    localparam int W = 8;

    typedef struct {
        logic [W-1:0] f;
        logic         co;
        logic         eq;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, cn_n = 1'b1, m = 1'b0, acc_en = 1'b0, acc_clr = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic [3:0]   s = '0;
    logic         in_ready1, out_valid1, cout_n1, aeqb1;
    logic         in_ready2, out_valid2, cout_n2, aeqb2;
    logic [W-1:0] f1, acc1, f2, acc2;

    exp_t         q1[$], q2[$];
    exp_t         cur1, cur2;
    logic         pv1 = 1'b0, pv2 = 1'b0;
    logic [W-1:0] acc_m = '0;
    logic         rdy_rand = 1'b0, rdy_force = 1'b1;
    int           cyc = 0, n_cmp = 0, n_bad = 0;

    alu181_seq #(.WIDTH(W), .PAR(1)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .s(s), .m(m), .cn_n(cn_n), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid1), .out_ready(out_ready), .f(f1), .cout_n(cout_n1),
        .aeqb(aeqb1), .acc(acc1)
    );

    alu181_seq #(.WIDTH(W), .PAR(2)) u2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .b(b), .s(s), .m(m), .cn_n(cn_n), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid2), .out_ready(out_ready), .f(f2), .cout_n(cout_n2),
        .aeqb(aeqb2), .acc(acc2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) out_ready = rdy_rand ? ($urandom_range(2) != 0) : rdy_force;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Whole-word reference: per-bit generate terms, then one wide add.
    function automatic void ref181(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic [3:0] sv, input logic mv, input logic cnv,
                                   output logic [W-1:0] fo, output logic co, output logic eq);
        logic [W-1:0] t1, t2, x, y;
        logic [W:0]   sum;
        t1  = (bv & {W{sv[0]}}) | (~bv & {W{sv[1]}});
        t2  = (bv & {W{sv[3]}}) | (~bv & {W{sv[2]}});
        x   = av | t1;
        y   = av & t2;
        sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~cnv};
        fo  = mv ? ~(x ^ y) : sum[W-1:0];
        co  = mv | ~sum[W];
        eq  = &fo;
    endfunction

    always @(negedge clk) begin
        if (rst) pv1 = 1'b0;
        else begin
            if (out_valid1 && !pv1) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_valid1: out_valid=1 with no op pending, expected 0");
                end else begin
                    cur1 = q1.pop_front();
                    chk("f1", 32'(f1), 32'(cur1.f));
                    chk("cout_n1", 32'(cout_n1), 32'(cur1.co));
                    chk("aeqb1", 32'(aeqb1), 32'(cur1.eq));
                    chk("latency1", 32'(cyc), 32'(cur1.cyc));
                end
            end else if (out_valid1) chk("hold_f1", 32'(f1), 32'(cur1.f));
            pv1 = out_valid1;
        end
    end

    always @(negedge clk) begin
        if (rst) pv2 = 1'b0;
        else begin
            if (out_valid2 && !pv2) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_valid2: out_valid=1 with no op pending, expected 0");
                end else begin
                    cur2 = q2.pop_front();
                    chk("f2", 32'(f2), 32'(cur2.f));
                    chk("cout_n2", 32'(cout_n2), 32'(cur2.co));
                    chk("aeqb2", 32'(aeqb2), 32'(cur2.eq));
                    chk("latency2", 32'(cyc), 32'(cur2.cyc));
                end
            end else if (out_valid2) chk("hold_f2", 32'(f2), 32'(cur2.f));
            pv2 = out_valid2;
        end
    end

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [3:0] sv,
                         input logic mv, input logic cnv, input logic aen, input logic clr);
        exp_t         e;
        logic [W-1:0] fo;
        logic         co, eq;
        int           t = 0;
        @(negedge clk);
        while (!(in_ready1 && in_ready2)) begin
            if (++t > 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ready_timeout: in_ready low for %0d cycles, expected 1", t);
                return;
            end
            @(negedge clk);
        end
        a = av; b = bv; s = sv; m = mv; cn_n = cnv; acc_en = aen; in_valid = 1'b1;
        ref181(aen ? acc_m : av, bv, sv, mv, cnv, fo, co, eq);
        if (aen) acc_m = fo;
        e.f = fo; e.co = co; e.eq = eq;
        e.cyc = cyc + 3; q1.push_back(e);
        e.cyc = cyc + 2; q2.push_back(e);
        @(negedge clk);
        // Both instances are busy now: this request and fresh operands must be ignored.
        a = W'($urandom); b = W'($urandom); s = 4'($urandom); m = 1'($urandom);
        cn_n = 1'($urandom); acc_en = 1'($urandom);
        if (clr) begin
            acc_clr = 1'b1;
            acc_m = '0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (clr) begin
            @(negedge clk);
            acc_clr = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (!(in_ready1 && in_ready2 && q1.size() == 0 && q2.size() == 0)) begin
            @(negedge clk);
            if (++t > 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", t);
                break;
            end
        end
    endtask

    task automatic clear_acc();
        wait_idle();
        acc_clr = 1'b1;
        acc_m = '0;
        @(negedge clk);
        acc_clr = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_f", 32'(f1), 32'h0);
        chk("rst_acc", 32'(acc1), 32'h0);
        chk("rst_cout_n", 32'(cout_n1), 32'h1);
        chk("rst_aeqb", 32'(aeqb1), 32'h0);
        chk("rst_out_valid", 32'(out_valid1), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_in_ready1", 32'(in_ready1), 32'h1);
        chk("rel_in_ready2", 32'(in_ready2), 32'h1);

        do_op(8'h01, 8'h00, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(8'h0F, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(8'h05, 8'h03, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(8'h5A, 8'h5A, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(8'h5A, 8'hA5, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op(8'h0F, 8'h3C, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);

        clear_acc();
        chk("acc_clr1", 32'(acc1), 32'h0);
        repeat (3) do_op(W'($urandom), 8'h03, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_idle();
        chk("acc_sum1", 32'(acc1), 32'(acc_m));
        chk("acc_sum2", 32'(acc2), 32'(acc_m));
        do_op(W'($urandom), 8'h05, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_idle();
        chk("acc_clr_wins1", 32'(acc1), 32'(acc_m));
        chk("acc_clr_wins2", 32'(acc2), 32'(acc_m));

        rdy_force = 1'b0;
        do_op(W'($urandom), W'($urandom), 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 20 && !(out_valid1 && out_valid2); t++) @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid1", 32'(out_valid1), 32'h1);
            chk("stall_valid2", 32'(out_valid2), 32'h1);
            chk("stall_in_ready1", 32'(in_ready1), 32'h0);
            chk("stall_in_ready2", 32'(in_ready2), 32'h0);
        end
        rdy_force = 1'b1;

        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(9) == 0) clear_acc();
            do_op(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'b0);
            if (i % 25 == 24) begin
                wait_idle();
                chk("rand_acc1", 32'(acc1), 32'(acc_m));
                chk("rand_acc2", 32'(acc2), 32'(acc_m));
            end
        end
        wait_idle();
        rdy_rand = 1'b0;

        clear_acc();
        do_op(8'h00, 8'h11, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0);
        do_op(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        @(negedge clk);
        a = 8'h11; b = 8'h22; s = 4'b1001; m = 1'b0; cn_n = 1'b1; acc_en = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        acc_m = '0;
        #1;
        chk("mid_rst_f1", 32'(f1), 32'h0);
        chk("mid_rst_acc1", 32'(acc1), 32'h0);
        chk("mid_rst_acc2", 32'(acc2), 32'h0);
        chk("mid_rst_cout_n1", 32'(cout_n1), 32'h1);
        chk("mid_rst_cout_n2", 32'(cout_n2), 32'h1);
        chk("mid_rst_aeqb1", 32'(aeqb1), 32'h0);
        chk("mid_rst_valid1", 32'(out_valid1), 32'h0);
        chk("mid_rst_valid2", 32'(out_valid2), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready1", 32'(in_ready1), 32'h1);
        chk("post_rst_in_ready2", 32'(in_ready2), 32'h1);
        repeat (4) @(negedge clk);
        do_op(8'h33, 8'h44, 4'b1001, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
